// File: rtl/uart_frame_sequencer_if.sv
// uart_frame_sequencer_if: FIFO read side and UART transmitter handshake bundle
interface uart_frame_sequencer_if;
  logic       fifo_rdempty;
  logic [7:0] fifo_q;
  logic       fifo_rdreq;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_wr_en;
  modport master (
    input  fifo_rdempty, fifo_q, tx_busy,
    output fifo_rdreq, tx_data, tx_wr_en
  );
  modport slave (
    output fifo_rdempty, fifo_q, tx_busy,
    input  fifo_rdreq, tx_data, tx_wr_en
  );
endinterface

// File: rtl/uart_frame_sequencer.sv
// uart_frame_sequencer: drains FIFO bytes into the UART as header/data/XOR-checksum frames
module uart_frame_sequencer #(
  parameter int         FRAME_LEN    = 8,
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic                          clk_50m,
  input  logic                          clr,
  input  logic                          enable,
  uart_frame_sequencer_if.master        bus,
  output logic                          frame_active,
  output logic [15:0]                   frame_count,
  output logic                          err_timeout
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, LOAD, STROBE, WAIT_HI, WAIT_LO} state_t;
  typedef enum logic [1:0] {R_HDR, R_DAT, R_CSM} ret_t;
  state_t      state, state_n;
  ret_t        ret, ret_n;
  logic [7:0]  data, data_n, csum, csum_n, idx, idx_n;
  logic [15:0] timer, timer_n, count_n;
  logic        active_n, err_n;
  assign bus.tx_data = data;
  always_ff @(posedge clk_50m) begin
    if (!clr) begin
      state        <= IDLE;
      ret          <= R_HDR;
      data         <= '0;
      csum         <= '0;
      idx          <= '0;
      timer        <= '0;
      frame_active <= 1'b0;
      frame_count  <= '0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_n;
      ret          <= ret_n;
      data         <= data_n;
      csum         <= csum_n;
      idx          <= idx_n;
      timer        <= timer_n;
      frame_active <= active_n;
      frame_count  <= count_n;
      err_timeout  <= err_n;
    end
  end
  always_comb begin
    state_n        = state;
    ret_n          = ret;
    data_n         = data;
    csum_n         = csum;
    idx_n          = idx;
    timer_n        = timer;
    active_n       = frame_active;
    count_n        = frame_count;
    err_n          = err_timeout;
    bus.fifo_rdreq = 1'b0;
    bus.tx_wr_en   = 1'b0;
    case (state)
      IDLE: if (enable && !bus.fifo_rdempty) begin
        active_n = 1'b1;
        csum_n   = '0;
        idx_n    = '0;
        data_n   = HEADER;
        ret_n    = R_HDR;
        state_n  = LOAD;
      end
      RD_REQ: if (!bus.fifo_rdempty) begin
        bus.fifo_rdreq = 1'b1;
        state_n        = RD_WAIT;
      end
      RD_WAIT: begin
        data_n  = bus.fifo_q;
        csum_n  = csum ^ bus.fifo_q;
        idx_n   = idx + 8'd1;
        ret_n   = R_DAT;
        state_n = LOAD;
      end
      LOAD: state_n = bus.tx_busy ? LOAD : STROBE;
      STROBE: begin
        bus.tx_wr_en = 1'b1;
        timer_n      = '0;
        state_n      = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.tx_busy) state_n = WAIT_LO;
        else if (timer == 16'(BUSY_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = WAIT_LO;
        end else timer_n = timer + 16'd1;
      end
      WAIT_LO: if (!bus.tx_busy) begin
        if (ret == R_CSM) begin
          active_n = 1'b0;
          count_n  = frame_count + 16'd1;
          state_n  = IDLE;
        end else if (ret == R_DAT && idx == 8'(FRAME_LEN)) begin
          data_n  = csum;
          ret_n   = R_CSM;
          state_n = LOAD;
        end else state_n = RD_REQ;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_frame_sequencer.sv
// tb_uart_frame_sequencer: FIFO/transmitter models with a frame-stream scoreboard
module tb_uart_frame_sequencer;
  logic clk_50m = 1'b0, clr = 1'b0, enable = 1'b0;
  logic frame_active, err_timeout;
  logic [15:0] frame_count;
  uart_frame_sequencer_if ifc();
  uart_frame_sequencer dut (
    .clk_50m(clk_50m), .clr(clr), .enable(enable), .bus(ifc),
    .frame_active(frame_active), .frame_count(frame_count), .err_timeout(err_timeout)
  );
  always #10 clk_50m = ~clk_50m;
  int total = 0, bad = 0;
  logic [7:0] fmem [0:255];
  logic [7:0] emem [0:255];
  int wp = 0, rp = 0, ewp = 0, erp = 0, bcnt = 0, strobes = 0;
  bit tie0 = 1'b0;
  assign ifc.fifo_rdempty = (wp == rp);
  assign ifc.tx_busy = (bcnt != 0);
  always @(posedge clk_50m) begin
    if (!clr) begin
      rp   <= wp;
      bcnt <= 0;
    end else begin
      if (ifc.fifo_rdreq) begin
        ifc.fifo_q <= fmem[rp];
        rp <= rp + 1;
      end
      if (ifc.tx_wr_en) strobes <= strobes + 1;
      bcnt <= (ifc.tx_wr_en && !tie0) ? 10 : (bcnt != 0 ? bcnt - 1 : 0);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk_50m) begin
    if (!clr) erp = ewp;
    else if (ifc.tx_wr_en) begin
      chk("rdreq_with_wr_en", {31'd0, ifc.fifo_rdreq}, 0);
      chk("active_on_wr", {31'd0, frame_active}, 1);
      if (erp < ewp) begin
        chk("tx_byte", {24'd0, ifc.tx_data}, {24'd0, emem[erp]});
        erp++;
      end else begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h want none", ifc.tx_data);
      end
    end
  end
  task automatic frame_exp(input int at);
    logic [7:0] x = 8'h00;
    emem[ewp] = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      emem[ewp+1+i] = fmem[at+i];
      x ^= fmem[at+i];
    end
    emem[ewp+9] = x;
    ewp += 10;
  endtask
  task automatic wait_frames(input int n, input string name);
    int c = 0;
    while (frame_count != 16'(n) && c < 3000) begin
      @(negedge clk_50m);
      c++;
    end
    chk(name, {16'd0, frame_count}, n);
  endtask
  task automatic wait_strobes(input int n, input string name);
    int c = 0;
    while (strobes < n && c < 1000) begin
      @(negedge clk_50m);
      c++;
    end
    chk(name, {31'd0, strobes >= n}, 1);
  endtask
  initial begin
    int s, c;
    logic [7:0] t3 [8];
    t3 = '{8'h10, 8'h20, 8'h30, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    repeat (3) @(negedge clk_50m);
    chk("rst_active", {31'd0, frame_active}, 0);
    chk("rst_count", {16'd0, frame_count}, 0);
    chk("rst_err", {31'd0, err_timeout}, 0);
    chk("rst_data", {24'd0, ifc.tx_data}, 0);
    chk("rst_strobes", {30'd0, ifc.tx_wr_en, ifc.fifo_rdreq}, 0);
    clr = 1'b1;
    for (int k = 0; k < 8; k++) fmem[k] = 8'hF1 + 8'(k);
    frame_exp(0);
    wp = 8;
    enable = 1'b1;
    wait_strobes(3, "t1_started");
    clr = 1'b0;
    repeat (5) @(negedge clk_50m);
    chk("t1_active", {31'd0, frame_active}, 0);
    chk("t1_data", {24'd0, ifc.tx_data}, 0);
    chk("t1_count", {16'd0, frame_count}, 0);
    chk("t1_strobes", {30'd0, ifc.tx_wr_en, ifc.fifo_rdreq}, 0);
    enable = 1'b0;
    clr = 1'b1;
    s = strobes;
    for (int k = 0; k < 8; k++) fmem[8+k] = 8'(k + 1);
    frame_exp(8);
    chk("model_t2_hdr", {24'd0, emem[ewp-10]}, 32'hA5);
    chk("model_t2_csum", {24'd0, emem[ewp-1]}, 32'h08);
    wp = 16;
    repeat (30) @(negedge clk_50m);
    chk("t1_no_start", strobes, s);
    chk("t1_idle_active", {31'd0, frame_active}, 0);
    enable = 1'b1;
    wait_frames(1, "t2_frames");
    chk("t2_drained", erp, ewp);
    chk("t2_err", {31'd0, err_timeout}, 0);
    chk("t2_active", {31'd0, frame_active}, 0);
    for (int k = 0; k < 8; k++) fmem[16+k] = t3[k];
    frame_exp(16);
    chk("model_t3_csum", {24'd0, emem[ewp-1]}, 32'h88);
    s = strobes;
    wp = 19;
    repeat (300) @(negedge clk_50m);
    chk("t3_stall_count", {16'd0, frame_count}, 1);
    chk("t3_stall_rdreq", {31'd0, ifc.fifo_rdreq}, 0);
    chk("t3_stall_active", {31'd0, frame_active}, 1);
    chk("t3_stall_strobes", strobes, s + 4);
    wp = 24;
    wait_frames(2, "t3_frames");
    chk("t3_drained", erp, ewp);
    for (int k = 0; k < 16; k++) fmem[24+k] = 8'h21 + 8'(k);
    frame_exp(24);
    s = strobes;
    wp = 40;
    wait_strobes(s + 3, "t4_started");
    enable = 1'b0;
    wait_frames(3, "t4_frames");
    repeat (50) @(negedge clk_50m);
    chk("t4_count_held", {16'd0, frame_count}, 3);
    chk("t4_idle_active", {31'd0, frame_active}, 0);
    chk("t4_fifo_left", {31'd0, ifc.fifo_rdempty}, 0);
    chk("t4_strobes", strobes, s + 10);
    chk("t4_drained", erp, ewp);
    tie0 = 1'b1;
    frame_exp(32);
    enable = 1'b1;
    c = 0;
    do begin
      @(negedge clk_50m);
      c++;
    end while (!ifc.tx_wr_en && c < 100);
    chk("t5_strobe_seen", {31'd0, ifc.tx_wr_en}, 1);
    repeat (14) @(negedge clk_50m);
    chk("t5_err_early", {31'd0, err_timeout}, 0);
    repeat (4) @(negedge clk_50m);
    chk("t5_err_set", {31'd0, err_timeout}, 1);
    wait_frames(4, "t5_frames");
    enable = 1'b0;
    tie0 = 1'b0;
    chk("t5_drained", erp, ewp);
    for (int k = 0; k < 24; k++) fmem[40+k] = 8'(k * 7 + 3);
    frame_exp(40);
    frame_exp(48);
    frame_exp(56);
    wp = 64;
    enable = 1'b1;
    wait_frames(7, "t6_frames");
    chk("t6_drained", erp, ewp);
    chk("t6_err_sticky", {31'd0, err_timeout}, 1);
    chk("t6_active", {31'd0, frame_active}, 0);
    clr = 1'b0;
    repeat (2) @(negedge clk_50m);
    chk("final_rst_err", {31'd0, err_timeout}, 0);
    chk("final_rst_count", {16'd0, frame_count}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
